// File: rtl/serial_complement_pkg.sv
// Shared types and constants for the bit-serial complement unit.
// Holds the FSM state encoding and the mode selector values.
package serial_complement_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic MODE_ONES = 1'b0;
  localparam logic MODE_TWOS = 1'b1;

endpackage

// File: rtl/complement_bit_cell.sv
// One-bit combinational complement step, applied LSB first.
// Ports: a_i, mode, seen_one in; r_i, next_seen_one out.
module complement_bit_cell
  import serial_complement_pkg::*;
(
  input  logic a_i,
  input  logic mode,
  input  logic seen_one,
  output logic r_i,
  output logic next_seen_one
);

  // Two's complement copies bits up to and including the
  // first 1, then inverts the rest.
  always_comb begin
    r_i = ~a_i;
    if (mode == MODE_TWOS && !seen_one) r_i = a_i;
  end

  assign next_seen_one = seen_one | a_i;

endmodule

// File: rtl/serial_complement.sv
// Bit-serial ones'/two's complement with start/busy/done.
// Ports: clk, rst, start, mode, a in; busy, done, result,
// overflow, zero out (all registered).
module serial_complement
  import serial_complement_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             zero
);

  localparam logic [WIDTH-1:0] MSB_ONLY =
    {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH-1);

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] cnt;
  logic             mode_q;
  logic             seen_one;
  logic             r_i;
  logic             next_seen_one;

  complement_bit_cell u_cell (
    .a_i          (sreg[0]),
    .mode         (mode_q),
    .seen_one     (seen_one),
    .r_i          (r_i),
    .next_seen_one(next_seen_one)
  );

  // New bit enters at the MSB; after WIDTH shifts the
  // first-processed bit has reached bit 0.
  assign acc_next = {r_i, acc[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      cnt      <= '0;
      seen_one <= 1'b0;
      sreg     <= '0;
      acc      <= '0;
      mode_q   <= MODE_ONES;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            sreg     <= a;
            mode_q   <= mode;
            cnt      <= '0;
            seen_one <= 1'b0;
            acc      <= '0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          sreg     <= sreg >> 1;
          acc      <= acc_next;
          seen_one <= next_seen_one;
          cnt      <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            // Only the two's complement of MSB_ONLY is
            // MSB_ONLY itself, so test the final result.
            result   <= acc_next;
            zero     <= (acc_next == '0);
            overflow <= (mode_q == MODE_TWOS) &&
                        (acc_next == MSB_ONLY);
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_complement.sv
// Directed self-checking bench for serial_complement.
// Drives ops via start and checks result/flags/timing.
module tb_serial_complement;

  logic       clk;
  logic       rst;
  logic       start;
  logic       mode;
  logic [7:0] a;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       overflow;
  logic       zero;

  int vectors;
  int miscompares;

  serial_complement #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mode    (mode),
    .a       (a),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .overflow(overflow),
    .zero    (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one op from IDLE; return latency (edges after
  // the accept edge until done) and busy-cycle count.
  task automatic do_op(input logic m,
                       input logic [7:0] v,
                       output int lat,
                       output int bcnt);
    start = 1'b1;
    mode  = m;
    a     = v;
    tick();
    start = 1'b0;
    a     = ~v;
    mode  = ~m;
    lat   = 0;
    bcnt  = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
  endtask

  task automatic check_res(input string tag,
                           input logic [7:0] r,
                           input logic ov,
                           input logic zr);
    check({tag, ".result"}, 64'(result), 64'(r));
    check({tag, ".ovf"}, 64'(overflow), 64'(ov));
    check({tag, ".zero"}, 64'(zero), 64'(zr));
  endtask

  initial begin
    int lat;
    int bcnt;
    int pulses;
    logic [7:0] exp_r;
    logic [7:0] v;
    vectors     = 0;
    miscompares = 0;
    rst   = 1'b1;
    start = 1'b0;
    mode  = 1'b0;
    a     = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check_res("rst", 8'h00, 1'b0, 1'b0);
    tick();

    // 1: two's of 06
    do_op(1'b1, 8'h06, lat, bcnt);
    check("t1.latency", 64'(lat), 64'd8);
    check("t1.busy_cycles", 64'(bcnt), 64'd8);
    check("t1.busy_at_done", 64'(busy), 64'd0);
    check_res("t1", 8'hFA, 1'b0, 1'b0);
    tick();
    check("t1.done_drop", 64'(done), 64'd0);
    check("t1.hold", 64'(result), 64'hFA);

    // 2: ones' complement
    do_op(1'b0, 8'hA5, lat, bcnt);
    check_res("t2a", 8'h5A, 1'b0, 1'b0);
    tick();
    do_op(1'b0, 8'hFF, lat, bcnt);
    check_res("t2b", 8'h00, 1'b0, 1'b1);
    tick();

    // 3: two's boundaries
    do_op(1'b1, 8'h80, lat, bcnt);
    check_res("t3a", 8'h80, 1'b1, 1'b0);
    tick();
    do_op(1'b1, 8'h00, lat, bcnt);
    check_res("t3b", 8'h00, 1'b0, 1'b1);
    tick();
    do_op(1'b0, 8'h80, lat, bcnt);
    check_res("t3c", 8'h7F, 1'b0, 1'b0);
    tick();

    // 4: start while busy is ignored
    start = 1'b1;
    mode  = 1'b1;
    a     = 8'h01;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    a     = 8'h33;
    tick();
    start  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      if (done) pulses++;
      tick();
    end
    check("t4.pulses", 64'(pulses), 64'd1);
    check_res("t4", 8'hFF, 1'b0, 1'b0);
    do_op(1'b1, 8'h33, lat, bcnt);
    check("t4.latency", 64'(lat), 64'd8);
    check_res("t4b", 8'hCD, 1'b0, 1'b0);
    tick();

    // 5: reset mid-shift
    start = 1'b1;
    mode  = 1'b0;
    a     = 8'h12;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5.busy", 64'(busy), 64'd0);
    check("t5.done", 64'(done), 64'd0);
    check("t5.result", 64'(result), 64'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) pulses++;
      tick();
    end
    check("t5.no_activity", 64'(pulses), 64'd0);
    do_op(1'b0, 8'h12, lat, bcnt);
    check("t5.latency", 64'(lat), 64'd8);
    check_res("t5b", 8'hED, 1'b0, 1'b0);
    tick();

    // 6: sweep both modes, start at first IDLE cycle
    for (int m = 0; m < 2; m++) begin
      for (int n = 0; n < 1000; n++) begin
        v = 8'($urandom);
        if (n == 0) v = 8'h80;
        if (n == 1) v = 8'h00;
        if (n == 2) v = 8'hFF;
        exp_r = (m == 1) ? 8'(~v + 8'd1) : ~v;
        do_op(m[0], v, lat, bcnt);
        if (lat != 8)
          check("t6.latency", 64'(lat), 64'd8);
        if (result !== exp_r)
          check("t6.result", 64'(result), 64'(exp_r));
        if (overflow !== (m == 1 && v == 8'h80))
          check("t6.ovf", 64'(overflow),
                64'(m == 1 && v == 8'h80));
        if (zero !== (exp_r == 8'h00))
          check("t6.zero", 64'(zero), 64'(exp_r == 8'h00));
        tick();
      end
      check("t6.last", 64'(result), 64'(exp_r));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
